smpl_circ_queue: RTL and testbench
==================================

Name: smpl_circ_queue

Overview:
Circular sample queue that feeds the FIR band filters. It stores incoming stereo audio samples and, once TAPS samples are held, replays the most recent TAPS samples oldest-first on every new sample. Replay runs one sample per clock under a `sequencing` strobe, time-aligned to the downstream coefficient-ROM latency. It sits between the sample-rate I2S/decimation front end and the FIR_* MAC stages.

Parameters:
DEPTH, 1536, storage entries per channel (must be > TAPS)
TAPS, 1021, samples replayed per sequence (FIR length)
PTR_W, 11, pointer width (ceil log2 DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wrt_smpl  in  1  one-cycle strobe: new stereo sample valid
lft_smpl  in  16  signed left sample, valid with wrt_smpl
rght_smpl  in  16  signed right sample, valid with wrt_smpl
lft_out  out  16  signed replayed left sample
rght_out  out  16  signed replayed right sample
sequencing  out  1  high while a replay is in progress (FIR enable)
full  out  1  high once TAPS samples have been stored since reset

Behaviour:
- Reset (async, rst=1): new_ptr=0, rd_ptr=0, fill count=0, pend=0, state=IDLE. Outputs sequencing=0, full=0, lft_out=0, rght_out=0. Reset mid-sequence aborts the replay immediately; stored data is don't-care afterwards.
- Storage: two DEPTH×16 arrays (left/right). Write is synchronous. Read is synchronous with 1-cycle latency (registered read data drives lft_out/rght_out).
- Write: on any edge with wrt_smpl=1, store lft_smpl/rght_smpl at new_ptr; new_ptr <= new_ptr+1, wrapping DEPTH-1 -> 0.
  - Writes are accepted in every state, including during a replay.
- Fill count: increments on each write and saturates at TAPS. full=1 when count==TAPS (registered, visible the cycle after the TAPS-th write).
- Sequence trigger: a write that makes or leaves count==TAPS requests a replay. start = (new_ptr after write) - TAPS, mod DEPTH.
- FSM states:
  - IDLE: on request -> SEQ. The cycle after the triggering write edge: rd_ptr=start, sequencing=1 (cycle S0), first read issued.
  - SEQ: sequencing stays high exactly TAPS+1 cycles (S0..S_TAPS).
    - Reads are issued at S0..S_TAPS-1 with rd_ptr incrementing and wrapping at DEPTH.
    - lft_out/rght_out carry sample k at cycle S(k+1), for k=0..TAPS-1, oldest first. This matches the FIR's one-cycle ROM latency: coefficient k aligns with sample k.
    - After S_TAPS: sequencing=0. Go to IDLE, or to SEQ again if pend=1.
- Write during SEQ (queue full): pend <= 1 and the new start is latched. The current replay is unaffected; the window was fixed at its start, and the write address is outside it because DEPTH > TAPS.
  - The pended replay begins the cycle after sequencing falls, with sequencing low for exactly one cycle between replays.
  - A further write while pend=1 overwrites the latched start (only the newest window is replayed).
- Outputs between sequences hold the last read value; the consumer ignores them when sequencing=0.
- Simultaneous write and replay end: the pend is honoured, with no lost request.

Test Plan:
1. Reset, then 1020 writes (value = index) -> full=0, sequencing never asserts.
2. 1021st write at edge t -> full=1 and sequencing=1 from t+1 for 1022 cycles. lft_out = 0,1,…,1020 at S1..S1021. rght_out mirrors with the right-channel values.
3. 1022nd write after the replay completes -> replay outputs 1..1021, and sequencing is high exactly 1022 cycles.
4. 1600 sequential writes (each after the prior replay) -> final replay outputs 579..1599 in order across the pointer wrap at 1535->0.
5. Write at S500 of a replay -> current replay outputs are unchanged. sequencing is low for one cycle after S1021, then a second replay outputs the window shifted by one.
6. rst pulsed at S300 -> sequencing, full and outputs are 0 within the same cycle. 1020 subsequent writes produce no replay; the 1021st triggers one.

Source files
------------

// File: rtl/smpl_circ_queue_if.sv
// Sample-queue bus: stereo sample input strobe/data and the replay output stream.
interface smpl_circ_queue_if;
  logic               wrt_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
  logic               sequencing;
  logic               full;

  // Producer/consumer side: drives samples, observes the replay stream.
  modport master (
    output wrt_smpl,
    output lft_smpl,
    output rght_smpl,
    input  lft_out,
    input  rght_out,
    input  sequencing,
    input  full
  );

  // Queue side.
  modport slave (
    input  wrt_smpl,
    input  lft_smpl,
    input  rght_smpl,
    output lft_out,
    output rght_out,
    output sequencing,
    output full
  );
endinterface

// File: rtl/smpl_circ_queue.sv
// Circular stereo sample queue. Once TAPS samples are held, every new sample triggers
// a replay of the newest TAPS samples, oldest first, one per clock while sequencing=1.
// Read data is registered, so sample k appears one cycle after its read (cycle S(k+1)),
// lining up with the FIR coefficient ROM latency.
module smpl_circ_queue #(
  parameter int unsigned DEPTH = 1536,
  parameter int unsigned TAPS  = 1021,
  parameter int unsigned PTR_W = 11
) (
  input logic               clk,
  input logic               rst,
  smpl_circ_queue_if.slave  bus
);

  localparam int unsigned CntW = $clog2(TAPS + 1);

  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] TapsPtr = PTR_W'(TAPS);
  localparam logic [PTR_W-1:0] WrapAdj = PTR_W'(DEPTH - TAPS);
  localparam logic [CntW-1:0]  TapsCnt = CntW'(TAPS);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSeq  = 1'b1;

  // Sample storage, one array per channel.
  logic signed [15:0] lft_mem  [DEPTH];
  logic signed [15:0] rght_mem [DEPTH];

  logic [PTR_W-1:0] new_ptr_q, new_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] pend_start_q, pend_start_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  seq_cnt_q, seq_cnt_d;
  logic             pend_q, pend_d;
  logic [0:0]       state_q, state_d;
  logic signed [15:0] lft_q, rght_q;

  logic [PTR_W-1:0] new_ptr_inc;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [PTR_W-1:0] win_start;
  logic             req;
  logic             rd_en;

  // Write pointer, fill count and the start of the window ending at this write.
  always_comb begin
    new_ptr_inc = (new_ptr_q == LastPtr) ? '0 : new_ptr_q + PTR_W'(1);
    rd_ptr_inc  = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PTR_W'(1);
    // start = (new_ptr after write) - TAPS, modulo DEPTH
    win_start   = (new_ptr_inc >= TapsPtr) ? new_ptr_inc - TapsPtr : new_ptr_inc + WrapAdj;

    new_ptr_d = new_ptr_q;
    cnt_d     = cnt_q;
    if (bus.wrt_smpl) begin
      new_ptr_d = new_ptr_inc;
      if (cnt_q != TapsCnt) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    // A write that makes or keeps the queue full asks for a replay.
    req = bus.wrt_smpl && (cnt_d == TapsCnt);
  end

  // Replay sequencer: start/pend bookkeeping and read-pointer walk.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    seq_cnt_d    = seq_cnt_q;
    pend_d       = pend_q;
    pend_start_d = pend_start_q;
    rd_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A fresh write wins over an older pended window.
        if (req) begin
          state_d   = StSeq;
          rd_ptr_d  = win_start;
          seq_cnt_d = '0;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          state_d   = StSeq;
          rd_ptr_d  = pend_start_q;
          seq_cnt_d = '0;
          pend_d    = 1'b0;
        end
      end
      StSeq: begin
        if (seq_cnt_q != TapsCnt) begin
          rd_en     = 1'b1;
          rd_ptr_d  = rd_ptr_inc;
          seq_cnt_d = seq_cnt_q + CntW'(1);
        end else begin
          // Last cycle only shows the final sample; always pass through idle once.
          state_d = StIdle;
        end
        // Window of the running replay is fixed; only the newest request is kept.
        if (req) begin
          pend_d       = 1'b1;
          pend_start_d = win_start;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      pend_start_q <= '0;
      cnt_q        <= '0;
      seq_cnt_q    <= '0;
      pend_q       <= 1'b0;
      state_q      <= StIdle;
    end else begin
      new_ptr_q    <= new_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_start_q <= pend_start_d;
      cnt_q        <= cnt_d;
      seq_cnt_q    <= seq_cnt_d;
      pend_q       <= pend_d;
      state_q      <= state_d;
    end
  end

  // Sample arrays: synchronous write, accepted in every state.
  always_ff @(posedge clk) begin
    if (bus.wrt_smpl) begin
      lft_mem[new_ptr_q]  <= bus.lft_smpl;
      rght_mem[new_ptr_q] <= bus.rght_smpl;
    end
  end

  // Registered read data; holds the last sample between replays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (rd_en) begin
      lft_q  <= lft_mem[rd_ptr_q];
      rght_q <= rght_mem[rd_ptr_q];
    end
  end

  assign bus.lft_out    = lft_q;
  assign bus.rght_out   = rght_q;
  assign bus.sequencing = (state_q == StSeq);
  assign bus.full       = (cnt_q == TapsCnt);

endmodule

// File: tb/tb_smpl_circ_queue.sv
// Bench for smpl_circ_queue with a reduced geometry so that wrap, pend and
// reset corners are reached quickly.
module tb_smpl_circ_queue;

  localparam int unsigned DEPTH = 20;
  localparam int unsigned TAPS  = 13;
  localparam int unsigned PTR_W = 5;
  localparam int NV = 2 * TAPS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  smpl_circ_queue_if bus ();

  smpl_circ_queue #(
    .DEPTH(DEPTH),
    .TAPS (TAPS),
    .PTR_W(PTR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the last TAPS samples as queues, replay windows as copies of them.
  logic [15:0] h_l[$], h_r[$];
  logic [15:0] w_l[$], w_r[$];
  logic [15:0] p_l[$], p_r[$];
  int          m_pos = -1;  // offset inside the running replay, -1 when idle
  bit          m_pend = 1'b0;
  bit          was_seq;
  logic [15:0] m_out_l = '0, m_out_r = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h_l.delete(); h_r.delete();
      m_pos   = -1;
      m_pend  = 1'b0;
      m_out_l = '0;
      m_out_r = '0;
    end else begin
      was_seq = (m_pos >= 0);
      if (was_seq && m_pos < int'(TAPS)) begin
        m_out_l = w_l[m_pos];
        m_out_r = w_r[m_pos];
      end
      if (was_seq) m_pos = (m_pos == int'(TAPS)) ? -1 : m_pos + 1;
      else if (m_pend) begin
        w_l = p_l; w_r = p_r; m_pos = 0; m_pend = 1'b0;
      end
      if (bus.wrt_smpl) begin
        h_l.push_back(bus.lft_smpl);
        h_r.push_back(bus.rght_smpl);
        if (h_l.size() > int'(TAPS)) begin
          void'(h_l.pop_front());
          void'(h_r.pop_front());
        end
        if (h_l.size() == int'(TAPS)) begin
          if (was_seq) begin
            m_pend = 1'b1; p_l = h_l; p_r = h_r;
          end else begin
            w_l = h_l; w_r = h_r; m_pos = 0; m_pend = 1'b0;
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_seq", bus.sequencing, (m_pos >= 0));
      chk("mon_full", bus.full, (h_l.size() == int'(TAPS)));
      chk("mon_lft", bus.lft_out, m_out_l);
      chk("mon_rght", bus.rght_out, m_out_r);
    end
  end

  task automatic step(input logic w, input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    bus.wrt_smpl  = w;
    bus.lft_smpl  = l;
    bus.rght_smpl = r;
    @(posedge clk);
    #1;
    bus.wrt_smpl = 1'b0;
  endtask

  task automatic wait_seq(input logic val, input int budget);
    int n = 0;
    while (bus.sequencing !== val && n < budget) begin
      step(1'b0, 16'h0, 16'h0);
      n++;
    end
    chk("wait_seq", bus.sequencing, val);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] l;
    logic [15:0] r;
    logic        exp_full;
    logic        exp_seq;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    logic [15:0] v;

    // Fill phase: TAPS writes of value = index, then the first replay.
    for (int j = 0; j < int'(TAPS); j++) begin
      vecs[j].wr       = 1'b1;
      vecs[j].l        = 16'(j);
      vecs[j].r        = 16'hFFFF - 16'(j);
      vecs[j].exp_full = (j == int'(TAPS) - 1);
      vecs[j].exp_seq  = (j == int'(TAPS) - 1);
      vecs[j].exp_l    = 16'h0;
      vecs[j].exp_r    = 16'h0;
    end
    for (int m = 1; m <= int'(TAPS) + 1; m++) begin
      int k;
      k = (m - 1 < int'(TAPS) - 1) ? m - 1 : int'(TAPS) - 1;
      vecs[int'(TAPS) - 1 + m].wr       = 1'b0;
      vecs[int'(TAPS) - 1 + m].l        = 16'h0;
      vecs[int'(TAPS) - 1 + m].r        = 16'h0;
      vecs[int'(TAPS) - 1 + m].exp_full = 1'b1;
      vecs[int'(TAPS) - 1 + m].exp_seq  = (m <= int'(TAPS));
      vecs[int'(TAPS) - 1 + m].exp_l    = 16'(k);
      vecs[int'(TAPS) - 1 + m].exp_r    = 16'hFFFF - 16'(k);
    end

    bus.wrt_smpl  = 1'b0;
    bus.lft_smpl  = '0;
    bus.rght_smpl = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_seq", bus.sequencing, 1'b0);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_lft", bus.lft_out, 16'h0);
    chk("rst_rght", bus.rght_out, 16'h0);
    mon_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].wr, vecs[i].l, vecs[i].r);
      chk($sformatf("tbl%0d_full", i), bus.full, vecs[i].exp_full);
      chk($sformatf("tbl%0d_seq", i), bus.sequencing, vecs[i].exp_seq);
      chk($sformatf("tbl%0d_lft", i), bus.lft_out, vecs[i].exp_l);
      chk($sformatf("tbl%0d_rght", i), bus.rght_out, vecs[i].exp_r);
    end

    // One write per completed replay, long enough to wrap the pointers twice.
    for (int i = 0; i < 2 * int'(DEPTH); i++) begin
      v = 16'(int'(TAPS) + i);
      wait_seq(1'b0, 64);
      step(1'b1, v, ~v);
      chk("seqwr_start", bus.sequencing, 1'b1);
      wait_seq(1'b0, int'(TAPS) + 8);
    end

    // Write in the middle of a replay: one idle cycle, then the shifted window.
    step(1'b1, 16'h1234, 16'hEDCB);
    chk("pend_s0", bus.sequencing, 1'b1);
    repeat (5) step(1'b0, 16'h0, 16'h0);
    step(1'b1, 16'h1235, 16'hEDCA);
    wait_seq(1'b0, int'(TAPS) + 8);
    gap = 1;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 16'h0, 16'h0);
      if (bus.sequencing) break;
      gap++;
    end
    chk("pend_gap", 16'(gap), 16'd1);
    wait_seq(1'b0, int'(TAPS) + 8);

    // Write on the very edge that ends a replay must not be lost.
    step(1'b1, 16'h7FFF, 16'h8000);
    repeat (TAPS) step(1'b0, 16'h0, 16'h0);
    chk("end_last", bus.sequencing, 1'b1);
    step(1'b1, 16'h8001, 16'h7FFE);
    chk("end_gap", bus.sequencing, 1'b0);
    step(1'b0, 16'h0, 16'h0);
    chk("end_restart", bus.sequencing, 1'b1);
    wait_seq(1'b0, int'(TAPS) + 8);

    // Random traffic, including writes during replays and back-to-back pends.
    for (int i = 0; i < 4000; i++) begin
      v = 16'($urandom);
      step(($urandom_range(0, 6) == 0), v, 16'($urandom));
    end

    // Asynchronous reset in the middle of a replay.
    wait_seq(1'b0, 3 * int'(TAPS));
    wait_seq(1'b1, 64);
    if (!bus.sequencing) step(1'b1, 16'h0042, 16'h0024);
    repeat (4) step(1'b0, 16'h0, 16'h0);
    chk("pre_rst_seq", bus.sequencing, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_seq", bus.sequencing, 1'b0);
    chk("arst_full", bus.full, 1'b0);
    chk("arst_lft", bus.lft_out, 16'h0);
    chk("arst_rght", bus.rght_out, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int j = 0; j < int'(TAPS) - 1; j++) begin
      step(1'b1, 16'(100 + j), 16'(200 + j));
      chk("refill_seq", bus.sequencing, 1'b0);
    end
    chk("refill_full", bus.full, 1'b0);
    step(1'b1, 16'(100 + TAPS), 16'(200 + TAPS));
    chk("refill_trig", bus.sequencing, 1'b1);
    chk("refill_full2", bus.full, 1'b1);
    wait_seq(1'b0, int'(TAPS) + 8);
    step(1'b0, 16'h0, 16'h0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
